// File: rtl/comparador_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
//
// Shared definitions for the bit-serial magnitude comparator.
//   - state_t : control FSM states (IDLE, SHIFT, DONE)
//   - RES_*   : (f, g) result encodings. f = A > B, g = A < B, 00 = equal.
//               The combinational left-to-right chain uses the same encoding,
//               so downstream logic can consume either implementation.
//   - paso_bit: one-bit comparison step shared by the serial cell.
// -----------------------------------------------------------------------------
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b10;
  localparam logic [1:0] RES_LT = 2'b01;

  // One right-to-left step. A differing bit overrides whatever the lower bits
  // decided; equal bits keep the accumulated verdict. 'invert' swaps GT/LT,
  // which is how the two's-complement sign bit is handled.
  function automatic logic [1:0] paso_bit(input logic       a_i,
                                          input logic       b_i,
                                          input logic [1:0] acc,
                                          input logic       invert);
    logic [1:0] res;
    res = acc;
    if (a_i != b_i) begin
      res = (a_i ^ invert) ? RES_GT : RES_LT;
    end
    return res;
  endfunction

endpackage

// File: rtl/celda_serial.sv
// -----------------------------------------------------------------------------
// celda_serial
//
// Combinational one-bit step of the right-to-left comparator.
//
// Ports:
//   a_i, b_i       : current operand bits
//   acc_f, acc_g   : verdict accumulated over the less significant bits
//   invert         : swap the GT/LT verdict for this bit (sign bit handling)
//   next_f, next_g : updated verdict including this bit
// -----------------------------------------------------------------------------
module celda_serial
  import comparador_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic acc_f,
  input  logic acc_g,
  input  logic invert,
  output logic next_f,
  output logic next_g
);

  logic [1:0] res;

  always_comb begin
    res              = paso_bit(a_i, b_i, {acc_f, acc_g}, invert);
    {next_f, next_g} = res;
  end

endmodule

// File: rtl/comparador_serial_der_a_izq.sv
// -----------------------------------------------------------------------------
// comparador_serial_der_a_izq
//
// Bit-serial magnitude comparator. Two N-bit operands are captured on an
// accepted start and compared one bit per clock, LSB first. The most
// significant differing bit is the last one to write the accumulator, so it
// decides the result.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset
//   start  : request a comparison (accepted in IDLE or DONE)
//   A, B   : operands, sampled only at the accepting edge
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, f/g just updated
//   f      : A > B
//   g      : A < B   (f = g = 0 means A == B)
//
// Build option:
//   COMPARADOR_SIGNED_EN - operands are two's complement; the sign bit
//                          (processed last) has its verdict inverted.
//                          Undefined: unsigned comparison.
//
// Timing: start accepted at edge k -> busy from k to k+N, DONE (done=1,
// f/g valid) after edge k+N. Holding start gives one result every N+1 cycles.
// -----------------------------------------------------------------------------
module comparador_serial_der_a_izq
  import comparador_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         f,
  output logic         g
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  // Control state
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             acc_f_q, acc_f_d;
  logic             acc_g_q, acc_g_d;
  logic             f_q, f_d;
  logic             g_q, g_d;

  // Operand shift registers: pure datapath, always loaded before use
  logic [N-1:0]     a_sh_q, a_sh_d;
  logic [N-1:0]     b_sh_q, b_sh_d;

  logic             ultimo;
  logic             invert;
  logic             cel_f, cel_g;
  logic             accept;

  assign ultimo = (idx_q == IDX_LAST);

`ifdef COMPARADOR_SIGNED_EN
  // Only the sign bit is weighted negatively in two's complement.
  assign invert = ultimo;
`else
  assign invert = 1'b0;
`endif

  celda_serial u_celda (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .acc_f  (acc_f_q),
    .acc_g  (acc_g_q),
    .invert (invert),
    .next_f (cel_f),
    .next_g (cel_g)
  );

  // A request is taken both from IDLE and from DONE (back-to-back).
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_f_d = acc_f_q;
    acc_g_d = acc_g_q;
    f_d     = f_q;
    g_d     = g_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d            = SHIFT;
          idx_d              = '0;
          {acc_f_d, acc_g_d} = RES_EQ;
          a_sh_d             = A;
          b_sh_d             = B;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // start is ignored here; operands stay as captured.
        acc_f_d = cel_f;
        acc_g_d = cel_g;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (ultimo) begin
          // Index is frozen at N-1; it is cleared on the next accept.
          state_d = DONE;
          f_d     = cel_f;
          g_d     = cel_g;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_f_q <= 1'b0;
      acc_g_q <= 1'b0;
      f_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_f_q <= acc_f_d;
      acc_g_q <= acc_g_d;
      f_q     <= f_d;
      g_q     <= g_d;
    end
  end

  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign f    = f_q;
  assign g    = g_q;

endmodule
